// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the async FIFO read-side stream adapter.
// Default widths are also used by the FIFO bench.
package fifo_rd_pkg;

  localparam int unsigned DEF_DSIZE = 16;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carried out of the FIFO read adapter.
interface fifo_rd_stream_if #(
  parameter int unsigned DSIZE = 16
);

  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/fifo_rd_stream.sv
// Pops a first-word-fall-through FIFO into a 2-entry skid buffer and presents
// a registered valid/ready stream; counts delivered words.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DSIZE = DEF_DSIZE,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rempty,
  input  logic [DSIZE-1:0]     rdata,
  output logic                 rinc,
  fifo_rd_stream_if.master     m,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     pop_cnt
);

  occ_t             occ;
  logic             valid_q;
  logic [DSIZE-1:0] slot0;
  logic [DSIZE-1:0] slot1;
  logic             push;
  logic             fire;

  // Pop decision depends only on registered occupancy, never on m_ready.
  assign rinc = !rempty && (occ != OCC_TWO);
  assign push = rinc;
  assign fire = valid_q && m.m_ready;

  assign m.m_valid = valid_q;
  assign m.m_data  = slot0;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ     <= OCC_EMPTY;
      valid_q <= 1'b0;
      slot0   <= '0;
      slot1   <= '0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            occ     <= OCC_ONE;
            valid_q <= 1'b1;
            slot0   <= rdata;
          end
        end
        OCC_ONE: begin
          if (push && !fire) begin
            occ   <= OCC_TWO;
            slot1 <= rdata;
          end else if (!push && fire) begin
            occ     <= OCC_EMPTY;
            valid_q <= 1'b0;
          end else if (push && fire) begin
            slot0 <= rdata;
          end
        end
        OCC_TWO: begin
          if (fire) begin
            occ   <= OCC_ONE;
            slot0 <= slot1;
          end
        end
        default: begin
          occ     <= OCC_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Clear takes priority; a handshake in the clearing cycle is not counted.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pop_cnt <= '0;
    end else if (clr_cnt) begin
      pop_cnt <= '0;
    end else begin
      pop_cnt <= pop_cnt + CNT_W'(fire);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: directed vector table, hand sequences, and a
// randomized run checked against a queue-based model of the FIFO and stream.
module tb_fifo_rd_stream;
  import fifo_rd_pkg::*;

  localparam int unsigned DW = 16;

  logic          rclk    = 1'b0;
  logic          rrst_n  = 1'b1;
  logic          rempty  = 1'b1;
  logic          clr_cnt = 1'b0;
  logic [DW-1:0] rdata   = '0;
  logic          rinc;
  logic          rinc4;
  logic [15:0]   pop_cnt;
  logic [3:0]    pop_cnt4;

  fifo_rd_stream_if #(.DSIZE(DW)) s_if ();
  fifo_rd_stream_if #(.DSIZE(DW)) s4_if ();

  fifo_rd_stream #(.DSIZE(DW), .CNT_W(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .m(s_if), .clr_cnt(clr_cnt), .pop_cnt(pop_cnt)
  );

  fifo_rd_stream #(.DSIZE(DW), .CNT_W(4)) dut4 (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc4),
    .m(s4_if), .clr_cnt(clr_cnt), .pop_cnt(pop_cnt4)
  );

  always #5 rclk = ~rclk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int unsigned   exp_cnt   = 0;
  int unsigned   delivered = 0;
  int unsigned   dut_rincs = 0;

  typedef struct {
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rdy;
    logic          clr;
    logic          e_rinc;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [15:0]   e_cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_ready(input logic rdy);
    s_if.m_ready  = rdy;
    s4_if.m_ready = rdy;
  endtask

  // One cycle: drive at the falling edge, compare 1 time unit later, advance model.
  task automatic step(input logic rdy, input logic gate, input logic clr);
    logic        fire;
    logic        exp_rinc;
    int unsigned inflight;
    rempty  = gate || (src_q.size() == 0);
    rdata   = (src_q.size() != 0) ? src_q[0] : '0;
    clr_cnt = clr;
    drive_ready(rdy);
    #1;
    inflight = exp_q.size();
    exp_rinc = !rempty && (inflight < 2);
    check("rinc", {31'd0, rinc}, {31'd0, exp_rinc});
    check("m_valid", {31'd0, s_if.m_valid}, {31'd0, inflight != 0});
    if (inflight != 0) check("m_data", {16'd0, s_if.m_data}, {16'd0, exp_q[0]});
    check("pop_cnt", {16'd0, pop_cnt}, exp_cnt & 32'hFFFF);
    check("pop_cnt4", {28'd0, pop_cnt4}, exp_cnt % 16);
    if (rinc) dut_rincs++;
    fire = (inflight != 0) && rdy;
    if (fire) begin
      void'(exp_q.pop_front());
      delivered++;
    end
    if (exp_rinc) exp_q.push_back(src_q.pop_front());
    exp_cnt = clr ? 0 : exp_cnt + {31'd0, fire};
    @(negedge rclk);
  endtask

  task automatic model_clear();
    src_q.delete();
    exp_q.delete();
    exp_cnt = 0;
  endtask

  task automatic do_reset();
    rempty  = 1'b1;
    clr_cnt = 1'b0;
    drive_ready(1'b0);
    model_clear();
    #1;
    rrst_n = 1'b0;
    #2;
    check("rst_m_valid", {31'd0, s_if.m_valid}, 32'd0);
    check("rst_m_data", {16'd0, s_if.m_data}, 32'd0);
    check("rst_pop_cnt", {16'd0, pop_cnt}, 32'd0);
    check("rst_rinc", {31'd0, rinc}, 32'd0);
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0};
    tbl[1] = '{1'b0, 16'hA001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0};
    tbl[2] = '{1'b0, 16'hA002, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA001, 16'd0};
    tbl[3] = '{1'b0, 16'hA003, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA001, 16'd0};
    tbl[4] = '{1'b0, 16'hA003, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA001, 16'd0};
    tbl[5] = '{1'b0, 16'hA003, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA002, 16'd1};
    tbl[6] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA003, 16'd2};
    tbl[7] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA003, 16'd2};
    tbl[8] = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd3};
    tbl[9] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0};

    drive_ready(1'b0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      rempty  = tbl[i].rempty;
      rdata   = tbl[i].rdata;
      clr_cnt = tbl[i].clr;
      drive_ready(tbl[i].rdy);
      #1;
      check($sformatf("vec%0d_rinc", i), {31'd0, rinc}, {31'd0, tbl[i].e_rinc});
      check($sformatf("vec%0d_valid", i), {31'd0, s_if.m_valid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].e_valid || i == 0)
        check($sformatf("vec%0d_data", i), {16'd0, s_if.m_data}, {16'd0, tbl[i].e_data});
      check($sformatf("vec%0d_cnt", i), {16'd0, pop_cnt}, {16'd0, tbl[i].e_cnt});
      @(negedge rclk);
    end

    // Back-to-back burst of 8, then 9 more to wrap the 4-bit counter.
    do_reset();
    for (int w = 1; w <= 8; w++) src_q.push_back(DW'(w));
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 1'b0);
    check("burst_pop_cnt", {16'd0, pop_cnt}, 32'd8);
    for (int w = 9; w <= 17; w++) src_q.push_back(DW'(w));
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 1'b0);
    check("wrap_pop_cnt16", {16'd0, pop_cnt}, 32'd17);
    check("wrap_pop_cnt4", {28'd0, pop_cnt4}, 32'd1);

    // Stall with 5 words waiting: only two pops before backpressure.
    do_reset();
    for (int w = 1; w <= 5; w++) src_q.push_back(16'h0C00 + DW'(w));
    dut_rincs = 0;
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b0);
    check("stall_rinc_pulses", dut_rincs, 32'd2);
    check("stall_m_data", {16'd0, s_if.m_data}, 32'h0C01);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 1'b0);
    check("stall_drained_cnt", {16'd0, pop_cnt}, 32'd5);

    // Counter clear coinciding with a handshake.
    do_reset();
    for (int w = 1; w <= 8; w++) src_q.push_back(16'h5500 + DW'(w));
    for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 1'b0);
    check("clr_pre_cnt", {16'd0, pop_cnt}, 32'd5);
    step(1'b1, 1'b0, 1'b1);
    check("clr_cnt_zero", {16'd0, pop_cnt}, 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("clr_next_fire", {16'd0, pop_cnt}, 32'd1);

    // Asynchronous reset while both slots are full.
    do_reset();
    for (int w = 1; w <= 4; w++) src_q.push_back(16'h0D00 + DW'(w));
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", {31'd0, s_if.m_valid}, 32'd1);
    rempty = 1'b1;
    #2;
    rrst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, s_if.m_valid}, 32'd0);
    check("async_rst_cnt", {16'd0, pop_cnt}, 32'd0);
    model_clear();
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int w = 1; w <= 3; w++) src_q.push_back(16'h0E00 + DW'(w));
    step(1'b0, 1'b0, 1'b0);
    check("post_rst_first", {16'd0, s_if.m_data}, 32'h0E01);
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 1'b0);

    // Random traffic: bursty producer, random empty gaps and backpressure.
    do_reset();
    begin
      int unsigned produced;
      produced  = 0;
      delivered = 0;
      for (int c = 0; c < 20000; c++) begin
        if (produced < 1000 && $urandom_range(0, 2) != 0) begin
          src_q.push_back(DW'($urandom));
          produced++;
        end
        step(1'(($urandom_range(0, 1))), ($urandom_range(0, 3) == 0), 1'b0);
        if (produced == 1000 && src_q.size() == 0 && exp_q.size() == 0) break;
      end
      check("rand_delivered", delivered, 32'd1000);
      check("rand_pop_cnt", {16'd0, pop_cnt}, 32'd1000);
      check("rand_pop_cnt4", {28'd0, pop_cnt4}, 32'd8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
